// File: rtl/ball_launcher_pkg.sv
// Shared constants and state type for the spring-lane ball launcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ball_launcher_pkg;

    // Screen geometry for the main playfield launch lane.
    localparam int SCREEN_MAIN_BALL_HEIGHT = 16;
    localparam int SCREEN_MAIN_LANE_X      = 600;
    localparam int SCREEN_MAIN_LANE_EXIT_Y = 64;

    // Physics: pixels/frame added to vertical speed each frame (down is positive).
    localparam int PHYS_GRAVITY = 1;

    typedef enum logic [1:0] {
        REST    = 2'd0,
        FLY     = 2'd1,
        HANDOFF = 2'd2,
        DONE    = 2'd3
    } launcher_state_t;

    // Positions are computed in int and wrapped to the 11-bit signed screen range.
    function automatic logic signed [10:0] to_y11(input int v);
        return v[10:0];
    endfunction

endpackage

// File: rtl/ball_launcher.sv
// Holds the ball on the spring, flies it up the launch lane under gravity, hands it off.
// Latency: all outputs registered; REST tracks the spring 1 cycle late, FLY steps per frame tick.
// Backpressure: HANDOFF holds handoffValid with frozen position/speed until handoffReady.
//
// Ports:
//   clk, reset (sync, active-high), reset_level (sync restart, same effect as reset)
//   startOfFrame   : one-cycle frame tick driving the flight physics
//   springTopLeftY : spring head Y; ball rests BALL_HEIGHT above it
//   springSpeedY   : negative at spring release, sampled only in REST
//   ballTopLeftX/Y, ballSpeedY : ball state while in the lane
//   inLane         : low only once the ball has been handed off
//   handoffValid/handoffReady  : valid/ready offer of the ball to the ball controller
module ball_launcher
    import ball_launcher_pkg::*;
#(
    parameter int BALL_HEIGHT = SCREEN_MAIN_BALL_HEIGHT,
    parameter int LANE_X      = SCREEN_MAIN_LANE_X,
    parameter int LANE_EXIT_Y = SCREEN_MAIN_LANE_EXIT_Y,
    parameter int GRAVITY     = PHYS_GRAVITY
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               reset_level,
    input  logic signed [10:0] springTopLeftY,
    input  int                 springSpeedY,
    output logic signed [10:0] ballTopLeftX,
    output logic signed [10:0] ballTopLeftY,
    output int                 ballSpeedY,
    output logic               inLane,
    output logic               handoffValid,
    input  logic               handoffReady
);

    launcher_state_t    state_q, state_d;
    logic signed [10:0] y_q, y_d;
    int                 speed_q, speed_d;
    logic               valid_q, valid_d;
    logic               in_lane_q, in_lane_d;

    int                 rest_y_int;
    logic signed [10:0] rest_y;
    logic signed [10:0] fly_y;
    int                 fly_speed;

    always_comb begin
        // Resting position and the candidate next-frame flight step, both from old values.
        rest_y_int = int'(springTopLeftY) - BALL_HEIGHT;
        rest_y     = to_y11(rest_y_int);
        fly_y      = to_y11(int'(y_q) + speed_q);
        fly_speed  = speed_q + GRAVITY;

        state_d   = state_q;
        y_d       = y_q;
        speed_d   = speed_q;
        valid_d   = valid_q;
        in_lane_d = in_lane_q;

        if (reset || reset_level) begin
            state_d   = REST;
            y_d       = '0;
            speed_d   = 0;
            valid_d   = 1'b0;
            in_lane_d = 1'b1;
        end else begin
            unique case (state_q)
                REST: begin
                    y_d     = rest_y;
                    speed_d = 0;
                    if (startOfFrame && springSpeedY < 0) begin
                        speed_d = springSpeedY;
                        state_d = FLY;
                    end
                end
                FLY: begin
                    if (startOfFrame) begin
                        y_d     = fly_y;
                        speed_d = fly_speed;
                        // Lane exit wins over falling back onto the spring.
                        if (int'(fly_y) <= LANE_EXIT_Y) begin
                            state_d = HANDOFF;
                            valid_d = 1'b1;
                        end else if (fly_speed > 0 && int'(fly_y) >= rest_y_int) begin
                            state_d = REST;
                            y_d     = rest_y;
                            speed_d = 0;
                        end
                    end
                end
                HANDOFF: begin
                    if (handoffReady) begin
                        state_d   = DONE;
                        valid_d   = 1'b0;
                        in_lane_d = 1'b0;
                    end
                end
                DONE: begin
                    // Ball belongs to the ball controller; hold everything.
                end
                default: begin
                    state_d = REST;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        y_q       <= y_d;
        speed_q   <= speed_d;
        valid_q   <= valid_d;
        in_lane_q <= in_lane_d;
    end

    assign ballTopLeftX = 11'(LANE_X);
    assign ballTopLeftY = y_q;
    assign ballSpeedY   = speed_q;
    assign inLane       = in_lane_q;
    assign handoffValid = valid_q;

endmodule

// File: tb/tb_ball_launcher.sv
module tb_ball_launcher;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               startOfFrame = 1'b0;
    logic               reset_level = 1'b0;
    logic signed [10:0] springTopLeftY = 11'sd400;
    int                 springSpeedY = 0;
    logic signed [10:0] ballTopLeftX;
    logic signed [10:0] ballTopLeftY;
    int                 ballSpeedY;
    logic               inLane;
    logic               handoffValid;
    logic               handoffReady = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: ball phase plus position/speed in plain ints.
    localparam int M_REST = 0, M_FLY = 1, M_HAND = 2, M_DONE = 3;
    int m_phase = M_REST;
    int m_y = 0;
    int m_spd = 0;
    bit m_valid = 0;
    bit m_inlane = 1;

    ball_launcher dut (
        .clk(clk),
        .reset(reset),
        .startOfFrame(startOfFrame),
        .reset_level(reset_level),
        .springTopLeftY(springTopLeftY),
        .springSpeedY(springSpeedY),
        .ballTopLeftX(ballTopLeftX),
        .ballTopLeftY(ballTopLeftY),
        .ballSpeedY(ballSpeedY),
        .inLane(inLane),
        .handoffValid(handoffValid),
        .handoffReady(handoffReady)
    );

    always #5 clk = ~clk;

    function automatic int wrap11(input int v);
        int r;
        r = ((v % 2048) + 2048) % 2048;
        if (r >= 1024) r = r - 2048;
        return r;
    endfunction

    // Ball behaviour for one clock edge, written from the launcher's rules.
    task automatic model_step(input bit sof, input bit rdy, input bit rst, input int sy, input int ss);
        int rest_pos;
        int ny;
        int ns;
        rest_pos = sy - 16;
        if (rst) begin
            m_phase = M_REST; m_y = 0; m_spd = 0; m_valid = 0; m_inlane = 1;
        end else if (m_phase == M_REST) begin
            m_y = wrap11(rest_pos);
            m_spd = 0;
            if (sof && ss < 0) begin
                m_spd = ss;
                m_phase = M_FLY;
            end
        end else if (m_phase == M_FLY) begin
            if (sof) begin
                ny = wrap11(m_y + m_spd);
                ns = m_spd + 1;
                if (ny <= 64) begin
                    m_phase = M_HAND; m_y = ny; m_spd = ns; m_valid = 1;
                end else if (ns > 0 && ny >= rest_pos) begin
                    m_phase = M_REST; m_y = wrap11(rest_pos); m_spd = 0;
                end else begin
                    m_y = ny; m_spd = ns;
                end
            end
        end else if (m_phase == M_HAND) begin
            if (rdy) begin
                m_phase = M_DONE; m_valid = 0; m_inlane = 0;
            end
        end
    endtask

    // Apply one cycle of inputs, clock it, and sample 1 time unit after the edge.
    task automatic cyc(input bit sof, input bit rdy, input bit rst, input bit rl, input int sy, input int ss);
        startOfFrame   = sof;
        handoffReady   = rdy;
        reset          = rst;
        reset_level    = rl;
        springTopLeftY = 11'(sy);
        springSpeedY   = ss;
        @(posedge clk);
        model_step(sof, rdy, rst || rl, sy, ss);
        #1;
    endtask

    task automatic test_reset();
        cyc(0, 0, 1, 0, 400, 0);
        cyc(1, 1, 1, 0, 400, -10);
        n_vec++; if (ballTopLeftY !== 11'sd0) begin n_err++; $display("FAIL reset_y got %0d want 0", ballTopLeftY); end
        n_vec++; if (ballSpeedY !== 0) begin n_err++; $display("FAIL reset_speed got %0d want 0", ballSpeedY); end
        n_vec++; if (handoffValid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", handoffValid); end
        n_vec++; if (inLane !== 1'b1) begin n_err++; $display("FAIL reset_inlane got %b want 1", inLane); end
        n_vec++; if (ballTopLeftX !== 11'sd600) begin n_err++; $display("FAIL reset_x got %0d want 600", ballTopLeftX); end
    endtask

    task automatic test_rest_tracking();
        cyc(0, 0, 0, 0, 400, 0);
        n_vec++; if (ballTopLeftY !== 11'sd384) begin n_err++; $display("FAIL track_400 got %0d want 384", ballTopLeftY); end
        cyc(0, 0, 0, 0, 420, 0);
        n_vec++; if (ballTopLeftY !== 11'sd404) begin n_err++; $display("FAIL track_420 got %0d want 404", ballTopLeftY); end
        // Negative spring speed without a frame tick must not launch.
        cyc(0, 0, 0, 0, 420, -12);
        cyc(0, 0, 0, 0, 420, 0);
        n_vec++; if (ballSpeedY !== 0 || inLane !== 1'b1 || handoffValid !== 1'b0) begin
            n_err++; $display("FAIL track_nolaunch got speed %0d inLane %b valid %b want 0 1 0", ballSpeedY, inLane, handoffValid);
        end
    endtask

    task automatic test_launch();
        int ey;
        int es;
        bit exited;
        cyc(0, 0, 0, 0, 400, 0);
        cyc(1, 0, 0, 0, 400, -30);
        n_vec++; if (ballSpeedY !== -30 || ballTopLeftY !== 11'sd384) begin
            n_err++; $display("FAIL launch_latch got y %0d speed %0d want 384 -30", ballTopLeftY, ballSpeedY);
        end
        ey = 384; es = -30; exited = 0;
        for (int f = 0; f < 40 && !exited; f++) begin
            cyc(0, 0, 0, 0, 400, -5);   // ignored outside REST
            cyc(1, 0, 0, 0, 400, 0);
            ey = ey + es; es = es + 1;
            exited = (ey <= 64);
            n_vec++; if (ballTopLeftY !== 11'(ey) || ballSpeedY !== es) begin
                n_err++; $display("FAIL launch_frame%0d got y %0d speed %0d want %0d %0d", f, ballTopLeftY, ballSpeedY, ey, es);
            end
            n_vec++; if (handoffValid !== exited) begin
                n_err++; $display("FAIL launch_valid%0d got %b want %b", f, handoffValid, exited);
            end
        end
        if (!exited) begin n_err++; $display("FAIL launch_timeout got no exit want exit within 40 frames"); end
    endtask

    task automatic test_handoff_hold();
        logic signed [10:0] hy;
        int hs;
        hy = ballTopLeftY; hs = ballSpeedY;
        for (int f = 0; f < 5; f++) begin
            cyc(1, 0, 0, 0, 400, -7);
            cyc(0, 0, 0, 0, 400, 0);
        end
        n_vec++; if (handoffValid !== 1'b1 || ballTopLeftY !== hy || ballSpeedY !== hs || inLane !== 1'b1) begin
            n_err++; $display("FAIL hold got valid %b y %0d speed %0d want 1 %0d %0d", handoffValid, ballTopLeftY, ballSpeedY, hy, hs);
        end
        cyc(0, 1, 0, 0, 400, 0);
        n_vec++; if (handoffValid !== 1'b0 || inLane !== 1'b0) begin
            n_err++; $display("FAIL accept got valid %b inLane %b want 0 0", handoffValid, inLane);
        end
        cyc(1, 1, 0, 0, 300, -20);
        cyc(1, 0, 0, 0, 300, -20);
        n_vec++; if (inLane !== 1'b0 || ballTopLeftY !== hy || ballSpeedY !== hs || handoffValid !== 1'b0) begin
            n_err++; $display("FAIL done_hold got inLane %b y %0d speed %0d want 0 %0d %0d", inLane, ballTopLeftY, ballSpeedY, hy, hs);
        end
    endtask

    task automatic test_weak_shot();
        int exp_y[6] = '{381, 379, 378, 378, 379, 381};
        int exp_s[6] = '{-2, -1, 0, 1, 2, 3};
        cyc(0, 0, 1, 0, 400, 0);
        cyc(0, 0, 0, 0, 400, 0);
        cyc(1, 0, 0, 0, 400, -3);
        for (int f = 0; f < 6; f++) begin
            cyc(1, 0, 0, 0, 400, 0);
            n_vec++; if (ballTopLeftY !== 11'(exp_y[f]) || ballSpeedY !== exp_s[f]) begin
                n_err++; $display("FAIL weak_frame%0d got y %0d speed %0d want %0d %0d", f, ballTopLeftY, ballSpeedY, exp_y[f], exp_s[f]);
            end
        end
        cyc(1, 0, 0, 0, 400, 0);
        n_vec++; if (ballTopLeftY !== 11'sd384 || ballSpeedY !== 0 || handoffValid !== 1'b0) begin
            n_err++; $display("FAIL weak_return got y %0d speed %0d want 384 0", ballTopLeftY, ballSpeedY);
        end
        cyc(0, 0, 0, 0, 410, 0);
        n_vec++; if (ballTopLeftY !== 11'sd394) begin
            n_err++; $display("FAIL weak_rest_track got %0d want 394", ballTopLeftY);
        end
    endtask

    task automatic test_reset_level_in_flight();
        cyc(1, 0, 0, 0, 400, -20);
        cyc(1, 0, 0, 0, 400, 0);
        cyc(1, 0, 0, 0, 400, 0);
        n_vec++; if (ballTopLeftY !== 11'sd345) begin
            n_err++; $display("FAIL rl_pre got %0d want 345", ballTopLeftY);
        end
        cyc(1, 0, 0, 1, 400, 0);
        n_vec++; if (ballSpeedY !== 0 || ballTopLeftY !== 11'sd0 || inLane !== 1'b1) begin
            n_err++; $display("FAIL rl_reset got y %0d speed %0d inLane %b want 0 0 1", ballTopLeftY, ballSpeedY, inLane);
        end
        cyc(0, 0, 0, 0, 430, 0);
        n_vec++; if (ballTopLeftY !== 11'sd414 || ballSpeedY !== 0) begin
            n_err++; $display("FAIL rl_track got y %0d speed %0d want 414 0", ballTopLeftY, ballSpeedY);
        end
    endtask

    task automatic test_reset_vs_ready();
        bit got_valid;
        got_valid = 0;
        cyc(1, 0, 0, 0, 400, -40);
        for (int f = 0; f < 60 && !got_valid; f++) begin
            cyc(1, 0, 0, 0, 400, 0);
            got_valid = handoffValid;
        end
        if (!got_valid) begin n_err++; $display("FAIL rvr_timeout got no valid want valid within 60 frames"); end
        cyc(0, 1, 1, 0, 400, 0);
        n_vec++; if (inLane !== 1'b1 || handoffValid !== 1'b0 || ballTopLeftY !== 11'sd0) begin
            n_err++; $display("FAIL rvr got inLane %b valid %b y %0d want 1 0 0", inLane, handoffValid, ballTopLeftY);
        end
        cyc(0, 1, 0, 0, 400, 0);
        n_vec++; if (inLane !== 1'b1 || ballTopLeftY !== 11'sd384) begin
            n_err++; $display("FAIL rvr_rest got inLane %b y %0d want 1 384", inLane, ballTopLeftY);
        end
    endtask

    task automatic test_random();
        bit sof, rdy, rst, rl;
        int sy, ss;
        cyc(0, 0, 1, 0, 400, 0);
        for (int i = 0; i < 3000; i++) begin
            sof = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 299) == 0);
            rl  = ($urandom_range(0, 299) == 0);
            sy  = (i % 50 == 0) ? $urandom_range(150, 900) : int'(springTopLeftY);
            ss  = ($urandom_range(0, 9) == 0) ? -int'($urandom_range(1, 45)) : 0;
            cyc(sof, rdy, rst, rl, sy, ss);
            n_vec++;
            if (ballTopLeftY !== 11'(m_y) || ballSpeedY !== m_spd || handoffValid !== m_valid
                || inLane !== m_inlane || ballTopLeftX !== 11'sd600) begin
                n_err++;
                $display("FAIL rand%0d got y %0d spd %0d v %b in %b want y %0d spd %0d v %b in %b",
                         i, ballTopLeftY, ballSpeedY, handoffValid, inLane, m_y, m_spd, m_valid, m_inlane);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rest_tracking();
        test_launch();
        test_handoff_hold();
        test_weak_shot();
        test_reset_level_in_flight();
        test_reset_vs_ready();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
